// File: rtl/fl_tx_framer.sv
// FrameLink transmitter: turns a (header length, payload length) command plus a plain
// word stream into a two-part FrameLink frame with SOF/SOP/EOP/EOF and DREM.
module fl_tx_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                                  CLK,
    input  logic                                  RESET,
    input  logic                                  CMD_VALID,
    output logic                                  CMD_READY,
    input  logic [LEN_WIDTH-1:0]                  CMD_HDR_LEN,
    input  logic [LEN_WIDTH-1:0]                  CMD_PLD_LEN,
    input  logic [DATA_WIDTH-1:0]                 DIN,
    input  logic                                  DIN_VLD,
    output logic                                  DIN_RD,
    output logic [DATA_WIDTH-1:0]                 TX_DATA,
    output logic [$clog2(DATA_WIDTH/8)-1:0]       TX_DREM,
    output logic                                  TX_SOF_N,
    output logic                                  TX_EOF_N,
    output logic                                  TX_SOP_N,
    output logic                                  TX_EOP_N,
    output logic                                  TX_SRC_RDY_N,
    input  logic                                  TX_DST_RDY_N,
    output logic [31:0]                           STAT_FRAMES,
    output logic [1:0]                            DBG_STATE
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int DREM_W = $clog2(BYTES);
    localparam logic [DREM_W-1:0]    DREM_ONE = DREM_W'(1);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

    // Handshake: a command moves on a rising edge with CMD_VALID=1 and CMD_READY=1;
    // a data word moves when TX_SRC_RDY_N=0 and TX_DST_RDY_N=0, which is exactly DIN_RD=1.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PLD  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] hdr_len_q, pld_len_q;
    logic [LEN_WIDTH-1:0] word_idx, word_idx_nxt;
    logic [31:0]          stat_q;
    logic                 stat_inc;

    logic [LEN_WIDTH-1:0] cur_len;
    logic [LEN_WIDTH-1:0] cur_words;
    logic                 first_word, last_word, xfer;

    // Shift plus round-up bit: no intermediate sum, so a maximum length cannot overflow.
    function automatic logic [LEN_WIDTH-1:0] words_of(input logic [LEN_WIDTH-1:0] len);
        words_of = (len >> DREM_W) + {{(LEN_WIDTH-1){1'b0}}, |len[DREM_W-1:0]};
    endfunction

    always_comb begin
        cur_len    = (state == HDR) ? hdr_len_q : pld_len_q;
        cur_words  = words_of(cur_len);
        first_word = (word_idx == '0);
        last_word  = (word_idx == cur_words - LEN_ONE);
    end

    always_comb begin
        state_nxt    = state;
        word_idx_nxt = word_idx;
        stat_inc     = 1'b0;
        xfer         = 1'b0;
        CMD_READY    = 1'b0;
        DIN_RD       = 1'b0;
        TX_SRC_RDY_N = 1'b1;
        TX_SOF_N     = 1'b1;
        TX_EOF_N     = 1'b1;
        TX_SOP_N     = 1'b1;
        TX_EOP_N     = 1'b1;
        TX_DREM      = '1;
        if (!RESET) begin
            case (state)
                IDLE: begin
                    CMD_READY = 1'b1;
                    if (CMD_VALID && CMD_PLD_LEN != '0) begin
                        state_nxt    = (CMD_HDR_LEN != '0) ? HDR : PLD;
                        word_idx_nxt = '0;
                    end
                end
                HDR, PLD: begin
                    if (DIN_VLD) begin
                        TX_SRC_RDY_N = 1'b0;
                        TX_SOP_N     = !first_word;
                        TX_EOP_N     = !last_word;
                        TX_SOF_N     = !(first_word && (state == HDR || hdr_len_q == '0));
                        TX_EOF_N     = !(last_word && state == PLD);
                        if (last_word)
                            TX_DREM = cur_len[DREM_W-1:0] - DREM_ONE;
                    end
                    xfer   = DIN_VLD && !TX_DST_RDY_N;
                    DIN_RD = xfer;
                    if (xfer) begin
                        if (last_word) begin
                            word_idx_nxt = '0;
                            if (state == HDR) begin
                                state_nxt = PLD;
                            end else begin
                                state_nxt = IDLE;
                                stat_inc  = 1'b1;
                            end
                        end else begin
                            word_idx_nxt = word_idx + LEN_ONE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            word_idx  <= '0;
            hdr_len_q <= '0;
            pld_len_q <= '0;
            stat_q    <= '0;
        end else begin
            state    <= state_nxt;
            word_idx <= word_idx_nxt;
            if (CMD_VALID && CMD_READY) begin
                hdr_len_q <= CMD_HDR_LEN;
                pld_len_q <= CMD_PLD_LEN;
            end
            if (stat_inc)
                stat_q <= stat_q + 32'd1;
        end
    end

    assign TX_DATA     = DIN;
    assign STAT_FRAMES = stat_q;
    assign DBG_STATE   = state;

endmodule

// File: tb/tb_fl_tx_framer.sv
// Bench for fl_tx_framer: directed and randomized frames checked against a per-beat
// expectation list derived from the header/payload byte lengths.
module tb_fl_tx_framer;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready;
    logic [LW-1:0] cmd_hdr_len, cmd_pld_len;
    logic [DW-1:0] din;
    logic          din_vld, din_rd;
    logic [DW-1:0] tx_data;
    logic [1:0]    tx_drem;
    logic          tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n;
    logic          tx_src_rdy_n, tx_dst_rdy_n;
    logic [31:0]   stat_frames;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;
    logic [31:0] seq_word;
    // {sof, sop, eop, eof, drem[1:0], data[31:0]} per expected beat, flags active-high
    logic [37:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    fl_tx_framer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .CLK(clk), .RESET(rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_HDR_LEN(cmd_hdr_len), .CMD_PLD_LEN(cmd_pld_len),
        .DIN(din), .DIN_VLD(din_vld), .DIN_RD(din_rd),
        .TX_DATA(tx_data), .TX_DREM(tx_drem),
        .TX_SOF_N(tx_sof_n), .TX_EOF_N(tx_eof_n),
        .TX_SOP_N(tx_sop_n), .TX_EOP_N(tx_eop_n),
        .TX_SRC_RDY_N(tx_src_rdy_n), .TX_DST_RDY_N(tx_dst_rdy_n),
        .STAT_FRAMES(stat_frames), .DBG_STATE(dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: expected beats of one frame from its byte lengths
    task automatic build_frame(input int h, input int p, input bit seq);
        int lens[2];
        int beat;
        lens = '{h, p};
        beat = 0;
        for (int part = 0; part < 2; part++) begin
            int len;
            int nw;
            len = lens[part];
            nw  = (len + 3) / 4;
            for (int i = 0; i < nw; i++) begin
                logic [31:0] d;
                logic [1:0]  drem;
                bit          is_last;
                is_last = (i == nw - 1);
                if (seq) begin
                    d = seq_word;
                    seq_word++;
                end else begin
                    d = $urandom;
                end
                drem = is_last ? 2'((len - 1) % 4) : 2'd3;
                exp_q.push_back({beat == 0, i == 0, is_last, part == 1 && is_last, drem, d});
                beat++;
            end
        end
    endtask

    // driver: one data cycle, checked against the head of the expectation list
    task automatic drive_beat(input bit vld, input bit rdy);
        logic [37:0] e;
        e = exp_q[0];
        din          = vld ? e[31:0] : $urandom;
        din_vld      = vld;
        tx_dst_rdy_n = !rdy;
        #1;
        check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        if (!vld) begin
            check("gap_ctrl", 64'({tx_src_rdy_n, tx_sof_n, tx_sop_n, tx_eop_n, tx_eof_n, din_rd}),
                  64'(6'b111110));
        end else begin
            check("beat", 64'({~tx_sof_n, ~tx_sop_n, ~tx_eop_n, ~tx_eof_n, tx_drem, tx_data}), 64'(e));
            check("xfer", 64'({tx_src_rdy_n, din_rd}), 64'({1'b0, rdy}));
            if (rdy) void'(exp_q.pop_front());
        end
    endtask

    // driver: issue a command and push the whole frame through
    // mode 0: always valid/ready; 1: stall 3 cycles after first transfer;
    // 2: DIN_VLD toggles; 3: random valid/ready with junk commands while busy
    task automatic run_frame(input int h, input int p, input int mode, input bit seq);
        int  c;
        int  budget;
        bit  vld, rdy;
        build_frame(h, p, seq);
        budget = exp_q.size() * 8 + 40;
        @(negedge clk);
        cmd_valid    = 1'b1;
        cmd_hdr_len  = LW'(h);
        cmd_pld_len  = LW'(p);
        din_vld      = 1'b1;
        din          = $urandom;
        tx_dst_rdy_n = 1'b0;
        #1;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        check("idle_quiet", 64'({tx_src_rdy_n, tx_sof_n, tx_eof_n, din_rd}), 64'(4'b1110));
        @(posedge clk);
        c = 0;
        while (exp_q.size() > 0 && c < budget) begin
            @(negedge clk);
            if (mode == 3) begin
                cmd_valid   = 1'($urandom_range(0, 1));
                cmd_hdr_len = LW'($urandom);
                cmd_pld_len = LW'($urandom);
            end else begin
                cmd_valid = 1'b0;
            end
            case (mode)
                0:       begin vld = 1'b1;               rdy = 1'b1; end
                1:       begin vld = 1'b1;               rdy = !(c >= 1 && c <= 3); end
                2:       begin vld = (c % 2 == 0);       rdy = 1'b1; end
                default: begin vld = ($urandom_range(0, 3) != 0); rdy = ($urandom_range(0, 3) != 0); end
            endcase
            drive_beat(vld, rdy);
            c++;
            @(posedge clk);
        end
        check("frame_beats_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        exp_frames++;
        @(negedge clk);
        cmd_valid    = 1'b0;
        din_vld      = 1'b0;
        tx_dst_rdy_n = 1'b1;
        #1;
        check("cmd_ready_after_eof", 64'(cmd_ready), 64'd1);
        check("stat_frames", 64'(stat_frames), 64'(exp_frames));
    endtask

    initial begin
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_hdr_len  = '0;
        cmd_pld_len  = '0;
        din          = '0;
        din_vld      = 1'b0;
        tx_dst_rdy_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_ctrl", 64'({tx_src_rdy_n, tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n, din_rd}),
              64'(6'b111110));
        check("rst_stat", 64'(stat_frames), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // header 5 / payload 8 with data 1..4
        seq_word = 32'd1;
        run_frame(5, 8, 0, 1'b1);
        // single-word frame
        run_frame(0, 3, 0, 1'b0);
        // destination stall after first transfer
        run_frame(0, 12, 1, 1'b0);
        // DIN_VLD toggling
        run_frame(4, 4, 2, 1'b0);

        // zero-payload command dropped, then a 1-word frame back-to-back
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_hdr_len = '0;
        cmd_pld_len = '0;
        @(posedge clk);
        run_frame(0, 4, 0, 1'b0);

        // reset after word 2 of a 4-word payload
        build_frame(0, 16, 1'b0);
        @(negedge clk);
        cmd_valid   = 1'b1;
        cmd_hdr_len = '0;
        cmd_pld_len = LW'(16);
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            drive_beat(1'b1, 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        rst          = 1'b1;
        din_vld      = 1'b1;
        tx_dst_rdy_n = 1'b0;
        #1;
        check("midrst_src_rdy", 64'({tx_src_rdy_n, din_rd}), 64'(2'b10));
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        din_vld = 1'b0;
        #1;
        check("midrst_stat", 64'(stat_frames), 64'd0);
        check("midrst_cmd_ready_after", 64'(cmd_ready), 64'd1);
        check("midrst_src_rdy_after", 64'(tx_src_rdy_n), 64'd1);
        exp_q.delete();
        exp_frames = 0;
        run_frame(0, 4, 0, 1'b0);

        // maximum payload length
        run_frame(1, 65535, 0, 1'b0);

        // randomized frames
        for (int n = 0; n < 25; n++)
            run_frame($urandom_range(0, 9), $urandom_range(1, 24), 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fl_tx_framer.md
Name: fl_tx_framer

Overview:
- FrameLink transmitter: builds two-part frames (optional header part, then payload part) from a length command and a plain word stream.
- Drives a standard active-low FrameLink TX interface.
- Feeds the RX side of fl_fifo and other FrameLink consumers; it is the frame-producing end of the same protocol.
- Generates SOF/SOP/EOP/EOF and DREM from byte lengths, so upstream logic never handles FrameLink framing.

Parameters:
- DATA_WIDTH, 32, data word width in bits; multiple of 8, power of 2, 16..128.
- LEN_WIDTH, 16, width of byte-length fields.

Ports:
- CLK  in  1  clock.
- RESET  in  1  reset; synchronous, active-high.
- CMD_VALID  in  1  command valid.
- CMD_READY  out  1  command accepted when CMD_VALID=1 and CMD_READY=1 on a rising edge.
- CMD_HDR_LEN  in  LEN_WIDTH  header length in bytes; 0 = no header part.
- CMD_PLD_LEN  in  LEN_WIDTH  payload length in bytes.
- DIN  in  DATA_WIDTH  next data word, byte 0 in bits 7:0.
- DIN_VLD  in  1  DIN holds a valid word.
- DIN_RD  out  1  DIN consumed this cycle.
- TX_DATA  out  DATA_WIDTH  FrameLink data.
- TX_DREM  out  log2(DATA_WIDTH/8)  index of last valid byte.
- TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out  1 each  active-low frame and part delimiters.
- TX_SRC_RDY_N  out  1  active-low source ready.
- TX_DST_RDY_N  in  1  active-low destination ready.
- STAT_FRAMES  out  32  count of completed frames.

Behaviour:
- Words per part = ceil(len / BYTES), where BYTES = DATA_WIDTH/8.
- TX_DREM on the last word of a part = (len-1) mod BYTES; all ones on every other word.
- FSM states: IDLE, HDR, PLD.
- IDLE:
  - CMD_READY = 1 (forced 0 while RESET = 1); TX_SRC_RDY_N = 1; DIN_RD = 0.
  - On command accept, latch both lengths and load a word counter.
  - Accept with PLD_LEN = 0: command discarded, stay in IDLE, no output.
  - Otherwise go to HDR if HDR_LEN != 0, else to PLD.
- HDR and PLD:
  - CMD_READY = 0.
  - TX_DATA = DIN, combinational pass-through, zero latency.
  - TX_SRC_RDY_N = not DIN_VLD.
  - Transfer occurs when TX_SRC_RDY_N = 0 and TX_DST_RDY_N = 0; DIN_RD = 1 exactly in transfer cycles.
  - Without a transfer, the word counter and FSM hold.
  - Control outputs are stable while TX_DST_RDY_N = 1.
- Delimiters, asserted only together with TX_SRC_RDY_N = 0:
  - SOF_N = 0 on the first word of the frame (first HDR word, or first PLD word if there is no header).
  - SOP_N = 0 on the first word of each part; EOP_N = 0 on the last word of each part.
  - EOF_N = 0 on the last PLD word.
  - A single-word part asserts SOP and EOP together. A single-word frame asserts all four.
- Transitions:
  - HDR: transfer of the last header word goes to PLD.
  - PLD: transfer of the last payload word goes to IDLE and increments STAT_FRAMES, which wraps 0xFFFFFFFF -> 0.
  - CMD_READY is 1 in the cycle after the EOF transfer, so there is at least one idle cycle between frames.
- Reset values: CMD_READY = 0 during RESET, 1 after; TX_SRC_RDY_N = 1, TX_SOF_N, TX_EOF_N, TX_SOP_N and TX_EOP_N all 1, DIN_RD = 0, STAT_FRAMES = 0, state IDLE.
  - TX_DATA and TX_DREM are don't-care while TX_SRC_RDY_N = 1.
- Reset mid-frame: the frame is abandoned without EOF and the latched command is lost. The next accepted command starts with SOF.
- CMD_VALID while busy: ignored and held by upstream; no queueing.
- DIN_VLD low mid-part: TX_SRC_RDY_N = 1; delimiters resume on the correct word when DIN_VLD returns.
- Length arithmetic is done in LEN_WIDTH bits; maximum length 2^LEN_WIDTH - 1 bytes with no overflow.

Test Plan:
- DATA_WIDTH=32, HDR_LEN=5, PLD_LEN=8, DIN = 1, 2, 3, 4, TX_DST_RDY_N=0 -> 4 consecutive transfers:
  - w1: SOF, SOP, DREM=3.
  - w2: EOP, DREM=0.
  - w3: SOP, DREM=3.
  - w4: EOP, EOF, DREM=3.
  - STAT_FRAMES=1.
- HDR_LEN=0, PLD_LEN=3 -> one word with SOF, SOP, EOP, EOF all 0 and DREM=2; CMD_READY=1 the next cycle.
- HDR_LEN=0, PLD_LEN=12, TX_DST_RDY_N=1 for 3 cycles after the first transfer -> TX_DATA=word2 and all controls held, DIN_RD=0 for those cycles; total 3 transfers; EOF on word3 with DREM=3.
- DIN_VLD toggling 1,0,1,0,… with HDR_LEN=4, PLD_LEN=4 -> TX_SRC_RDY_N follows DIN_VLD; exactly 2 transfers, the first with SOF/SOP/EOP and the second with SOP/EOP/EOF.
- Commands (0,0) then (0,4) back-to-back -> first dropped with no TX activity; one 1-word frame follows; STAT_FRAMES=1.
- RESET asserted after word 2 of a 4-word payload -> next cycle TX_SRC_RDY_N=1, CMD_READY=0 then 1, STAT_FRAMES=0; the next command produces a fresh frame starting with SOF.
